// File: rtl/lz77_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : lz77_pkg                                                   |
// | Brief    : Shared FSM states, default terminator and width helper.    |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
package lz77_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FILL   = 3'd1,
      SEARCH = 3'd2,
      EMIT   = 3'd3,
      SHIFT  = 3'd4,
      DONE   = 3'd5
   } state_t;

   localparam logic [7:0] END_CHAR_DEFAULT = 8'h24;

   // Never returns 0 so that single-entry configurations keep a 1-bit field.
   function automatic int clog2(input int value);
      int width;
      width = 1;
      while ((1 << width) < value) width++;
      return width;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lz77_match_len.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : lz77_match_len                                             |
// | Brief    : Combinational prefix-match length of one candidate window. |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module lz77_match_len
   import lz77_pkg::*;
#(
   parameter  int CHAR_W   = 8,
   parameter  int LOOK_LEN = 8,
   localparam int LEN_W    = clog2(LOOK_LEN),
   localparam int CMP_N    = LOOK_LEN - 1
) (
   input  logic [CMP_N-1:0][CHAR_W-1:0] win_data,
   input  logic [CMP_N-1:0]             win_valid,
   input  logic [CMP_N-1:0][CHAR_W-1:0] look_data,
   input  logic [LEN_W:0]               lcnt,
   output logic [LEN_W:0]               len
);

   logic w_run;

   // Only positions below lcnt-1 may match so char_nxt is always a real character.
   always_comb begin
      len   = '0;
      w_run = 1'b1;
      for (int k = 0; k < CMP_N; k++) begin
         if (w_run && win_valid[k] && (win_data[k] == look_data[k]) &&
             ((LEN_W+1)'(k + 1) < lcnt))
            len = len + 1'b1;
         else
            w_run = 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/lz77_stream_encoder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : lz77_stream_encoder                                        |
// | Brief    : Streaming LZ77 encoder, one candidate offset per cycle.    |
// |            Optional tuple counter enabled by macro LZ77_STATS_EN.     |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module lz77_stream_encoder
   import lz77_pkg::*;
#(
   parameter  int                CHAR_W     = 8,
   parameter  int                SEARCH_LEN = 9,
   parameter  int                LOOK_LEN   = 8,
   parameter  logic [CHAR_W-1:0] END_CHAR   = CHAR_W'(END_CHAR_DEFAULT),
   localparam int                OFF_W      = clog2(SEARCH_LEN),
   localparam int                LEN_W      = clog2(LOOK_LEN)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CHAR_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OFF_W-1:0]  offset,
   output logic [LEN_W-1:0]  match_len,
   output logic [CHAR_W-1:0] char_nxt,
   output logic              encode,
   output logic              finish,
   output logic [15:0]       stat_tuples
);

   localparam int               CMP_N     = LOOK_LEN - 1;
   localparam logic [LEN_W:0]   LOOK_FULL = (LEN_W+1)'(LOOK_LEN);
   localparam logic [OFF_W-1:0] LAST_CAND = OFF_W'(SEARCH_LEN - 1);

   state_t                            r_state;
   state_t                            w_state_nxt;
   logic [SEARCH_LEN-1:0][CHAR_W-1:0] r_s_data;
   logic [SEARCH_LEN-1:0]             r_s_valid;
   logic [LOOK_LEN-1:0][CHAR_W-1:0]   r_l_data;
   logic [LEN_W:0]                    r_lcnt;
   logic                              r_end_seen;
   logic [OFF_W-1:0]                  r_cand;
   logic [OFF_W-1:0]                  r_best_off;
   logic [LEN_W:0]                    r_best_len;
   logic [LEN_W:0]                    r_shift_left;
   logic                              r_last_end;
   logic [CMP_N-1:0][CHAR_W-1:0]      w_win_data;
   logic [CMP_N-1:0]                  w_win_valid;
   logic [LEN_W:0]                    w_cand_len;
   logic [CHAR_W-1:0]                 w_emit_char;
   logic [LEN_W-1:0]                  w_wr_idx;
   logic                              w_accept;

   // Candidate o reads back through S, then runs on into the lookahead itself.
   always_comb begin
      for (int k = 0; k < CMP_N; k++) begin
         w_win_data[k]  = '0;
         w_win_valid[k] = 1'b0;
         if (k <= int'(r_cand)) begin
            w_win_data[k]  = r_s_data[OFF_W'(int'(r_cand) - k)];
            w_win_valid[k] = r_s_valid[OFF_W'(int'(r_cand) - k)];
         end else begin
            w_win_data[k]  = r_l_data[LEN_W'(k - int'(r_cand) - 1)];
            w_win_valid[k] = 1'b1;
         end
      end
   end

   lz77_match_len #(
      .CHAR_W   (CHAR_W),
      .LOOK_LEN (LOOK_LEN)
   ) u_match_len (
      .win_data  (w_win_data),
      .win_valid (w_win_valid),
      .look_data (r_l_data[CMP_N-1:0]),
      .lcnt      (r_lcnt),
      .len       (w_cand_len)
   );

   always_ff @(posedge clk) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      encode      = 1'b0;
      finish      = 1'b0;
      case (r_state)
         IDLE:   w_state_nxt = FILL;
         FILL: begin
            encode   = 1'b1;
            in_ready = (r_lcnt < LOOK_FULL) && !r_end_seen;
            if ((r_lcnt == LOOK_FULL) || r_end_seen) w_state_nxt = SEARCH;
         end
         SEARCH: begin
            encode = 1'b1;
            if (r_cand == LAST_CAND) w_state_nxt = EMIT;
         end
         EMIT: begin
            encode    = 1'b1;
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = SHIFT;
         end
         SHIFT: begin
            encode   = 1'b1;
            in_ready = (r_lcnt < LOOK_FULL) && !r_end_seen;
            if (r_shift_left == '0) w_state_nxt = r_last_end ? DONE : FILL;
         end
         DONE:    finish = 1'b1;
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_accept    = in_valid && in_ready;
   assign w_wr_idx    = LEN_W'((r_state == SHIFT) ? (r_lcnt - 1'b1) : r_lcnt);
   assign w_emit_char = r_l_data[r_best_len[LEN_W-1:0]];
   assign offset      = out_valid ? r_best_off : '0;
   assign match_len   = out_valid ? r_best_len[LEN_W-1:0] : '0;
   assign char_nxt    = out_valid ? w_emit_char : '0;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_s_data     <= '0;
         r_s_valid    <= '0;
         r_l_data     <= '0;
         r_lcnt       <= '0;
         r_end_seen   <= 1'b0;
         r_cand       <= '0;
         r_best_off   <= '0;
         r_best_len   <= '0;
         r_shift_left <= '0;
         r_last_end   <= 1'b0;
      end else begin
         case (r_state)
            FILL: begin
               r_cand     <= '0;
               r_best_off <= '0;
               r_best_len <= '0;
            end
            SEARCH: begin
               if (r_cand != LAST_CAND) r_cand <= r_cand + 1'b1;
               if (w_cand_len > r_best_len) begin
                  r_best_len <= w_cand_len;
                  r_best_off <= r_cand;
               end
            end
            EMIT: begin
               if (out_ready) begin
                  r_shift_left <= r_best_len;
                  r_last_end   <= (w_emit_char == END_CHAR);
               end
            end
            SHIFT: begin
               r_s_data     <= {r_s_data[SEARCH_LEN-2:0], r_l_data[0]};
               r_s_valid    <= {r_s_valid[SEARCH_LEN-2:0], 1'b1};
               r_l_data     <= {CHAR_W'(0), r_l_data[LOOK_LEN-1:1]};
               r_shift_left <= r_shift_left - 1'b1;
            end
            default: ;
         endcase
         // A refill during SHIFT lands one slot lower because L moves down this cycle.
         if (w_accept) begin
            r_l_data[w_wr_idx] <= in_data;
            if (in_data == END_CHAR) r_end_seen <= 1'b1;
         end
         if ((r_state == SHIFT) && !w_accept)      r_lcnt <= r_lcnt - 1'b1;
         else if ((r_state != SHIFT) && w_accept)  r_lcnt <= r_lcnt + 1'b1;
      end
   end

`ifdef LZ77_STATS_EN
   logic [15:0] r_stat_tuples;

   always_ff @(posedge clk) begin
      if (!reset)
         r_stat_tuples <= '0;
      else if (out_valid && out_ready && (r_stat_tuples != 16'hFFFF))
         r_stat_tuples <= r_stat_tuples + 1'b1;
   end

   assign stat_tuples = r_stat_tuples;
`else
   assign stat_tuples = 16'h0000;
`endif

endmodule
`default_nettype wire
